test_monitor: RTL and testbench

Synthesizable, parametrised self-checking monitor for CPU regression runs. Snoops the CPU write bus between core and memory. Compares writes to up to NUM_CHECKS configured result addresses against expected bytes, and bounds the run with a cycle timeout. Reports pass, fail or timeout, replacing fixed-delay end-of-test sampling of RAM in test benches and FPGA bring-up.

---
 rtl/test_monitor_pkg.sv | 20 ++
 rtl/monitor_channel.sv | 56 +++++
 rtl/test_monitor.sv | 127 ++++++++++++
 tb/tb_test_monitor.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/test_monitor_pkg.sv
// Shared types and sizing helpers for the regression test monitor.
package test_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2,
    ST_TMO  = 2'd3
  } mon_state_e;

  // Counter must be able to hold TIMEOUT_CYCLES itself (terminal count).
  function automatic int count_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/monitor_channel.sv
// One check channel: latches its address/expected byte during reset and
// tracks whether the most recent write to that address carried the expected value.
module monitor_channel #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active,
  input  logic                  cfg_en,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DATA_WIDTH-1:0] cfg_val,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_we,
  output logic                  hit,
  output logic                  hit_match,
  output logic                  hit_mismatch,
  output logic                  matched
);

  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] val_q, val_d;
  logic                  matched_q, matched_d;

  always_comb begin
    en_d         = en_q;
    addr_d       = addr_q;
    val_d        = val_q;
    hit          = active && en_q && bus_we && (bus_addr == addr_q);
    hit_match    = hit && (bus_wdata == val_q);
    hit_mismatch = hit && (bus_wdata != val_q);
    matched_d    = matched_q;
    if (reset) begin
      en_d      = cfg_en;
      addr_d    = cfg_addr;
      val_d     = cfg_val;
      matched_d = 1'b0;
    end else if (hit_match) begin
      matched_d = 1'b1;
    end else if (hit_mismatch) begin
      matched_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    en_q      <= en_d;
    addr_q    <= addr_d;
    val_q     <= val_d;
    matched_q <= matched_d;
  end

  assign matched = matched_q;

endmodule

// File: rtl/test_monitor.sv
// Bus-snooping pass/fail/timeout monitor: watches CPU writes to configured
// result addresses and issues a registered verdict, bounded by a cycle timeout.
module test_monitor
  import test_monitor_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_CHECKS     = 4,
  parameter int TIMEOUT_CYCLES = 175,
  parameter int STRICT         = 0,
  localparam int COUNT_WIDTH   = count_width(TIMEOUT_CYCLES),
  localparam int IDX_WIDTH     = idx_width(NUM_CHECKS)
) (
  input  logic                             ph2,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            bus_addr,
  input  logic [DATA_WIDTH-1:0]            bus_wdata,
  input  logic                             bus_we,
  input  logic [NUM_CHECKS-1:0]            check_en,
  input  logic [NUM_CHECKS*ADDR_WIDTH-1:0] check_addr,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0] check_val,
  output logic                             done,
  output logic                             pass,
  output logic                             fail,
  output logic                             timeout,
  output logic [IDX_WIDTH-1:0]             fail_index,
  output logic [NUM_CHECKS-1:0]            matched,
  output logic [COUNT_WIDTH-1:0]           cycle_count
);

  mon_state_e             state_q, state_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_WIDTH-1:0]   fidx_q, fidx_d;
  logic [NUM_CHECKS-1:0]  en_q, en_d;
  logic                   done_q, done_d, pass_q, pass_d;
  logic                   fail_q, fail_d, tmo_q, tmo_d;

  logic                   run;
  logic [NUM_CHECKS-1:0]  hit, hit_match, hit_mismatch, mm_vec, matched_nxt;
  logic [IDX_WIDTH-1:0]   mm_idx;
  logic                   fail_now, pass_now, tmo_now;

  assign run = (state_q == ST_RUN);

  for (genvar g = 0; g < NUM_CHECKS; g++) begin : g_ch
    monitor_channel #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .DATA_WIDTH(DATA_WIDTH)
    ) u_ch (
      .clk         (ph2),
      .reset       (reset),
      .active      (run),
      .cfg_en      (check_en[g]),
      .cfg_addr    (check_addr[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .cfg_val     (check_val[g*DATA_WIDTH +: DATA_WIDTH]),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_we      (bus_we),
      .hit         (hit[g]),
      .hit_match   (hit_match[g]),
      .hit_mismatch(hit_mismatch[g]),
      .matched     (matched[g])
    );
  end

  // Next-state match flags so the completing write itself yields PASS.
  assign mm_vec      = hit & hit_mismatch;
  assign matched_nxt = (matched | hit_match) & ~hit_mismatch;

  always_comb begin
    mm_idx = '0;
    for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
      if (mm_vec[i]) mm_idx = i[IDX_WIDTH-1:0];
    end
  end

  always_comb begin
    fail_now = (STRICT != 0) && (|mm_vec);
    pass_now = (en_q != '0) && ((matched_nxt & en_q) == en_q);
    tmo_now  = (cnt_q == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

    state_d = state_q;
    cnt_d   = cnt_q;
    fidx_d  = fidx_q;
    en_d    = en_q;
    if (reset) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      fidx_d  = '0;
      en_d    = check_en;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
      if (fail_now) begin
        state_d = ST_FAIL;
        fidx_d  = mm_idx;
      end else if (pass_now) begin
        state_d = ST_PASS;
      end else if (tmo_now) begin
        state_d = ST_TMO;
      end
    end

    done_d = (state_d != ST_RUN);
    pass_d = (state_d == ST_PASS);
    fail_d = (state_d == ST_FAIL) || (state_d == ST_TMO);
    tmo_d  = (state_d == ST_TMO);
  end

  always_ff @(posedge ph2) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    fidx_q  <= fidx_d;
    en_q    <= en_d;
    done_q  <= done_d;
    pass_q  <= pass_d;
    fail_q  <= fail_d;
    tmo_q   <= tmo_d;
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = tmo_q;
  assign fail_index  = fidx_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_test_monitor.sv
// Directed bench for test_monitor: a lenient and a strict instance share one
// stimulus stream; expected values are hand-computed constants.
module tb_test_monitor;

  logic        ph2 = 1'b0;
  logic        reset;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we;
  logic [3:0]  check_en;
  logic [63:0] check_addr;
  logic [31:0] check_val;

  logic       done0, pass0, fail0, tmo0;
  logic [1:0] fidx0;
  logic [3:0] m0;
  logic [7:0] cnt0;
  logic       done1, pass1, fail1, tmo1;
  logic [1:0] fidx1;
  logic [3:0] m1;
  logic [7:0] cnt1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 ph2 = ~ph2;

  test_monitor #(.STRICT(0)) u_lax (
    .ph2(ph2), .reset(reset), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .check_en(check_en), .check_addr(check_addr),
    .check_val(check_val), .done(done0), .pass(pass0), .fail(fail0),
    .timeout(tmo0), .fail_index(fidx0), .matched(m0), .cycle_count(cnt0)
  );

  test_monitor #(.STRICT(1)) u_strict (
    .ph2(ph2), .reset(reset), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .check_en(check_en), .check_addr(check_addr),
    .check_val(check_val), .done(done1), .pass(pass1), .fail(fail1),
    .timeout(tmo1), .fail_index(fidx1), .matched(m1), .cycle_count(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic we, input logic [15:0] a, input logic [7:0] d);
    bus_we = we; bus_addr = a; bus_wdata = d;
    @(posedge ph2);
    @(negedge ph2);
    bus_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0000, 8'h00);
  endtask

  task automatic do_reset(input logic [3:0] en, input logic [63:0] a, input logic [31:0] v);
    reset = 1'b1; check_en = en; check_addr = a; check_val = v;
    step(1'b0, 16'h0000, 8'h00);
    reset = 1'b0;
  endtask

  task automatic chk_idle0(input string tag);
    chk({tag, ".done"},  {31'd0, done0}, 32'd0);
    chk({tag, ".pass"},  {31'd0, pass0}, 32'd0);
    chk({tag, ".fail"},  {31'd0, fail0}, 32'd0);
    chk({tag, ".tmo"},   {31'd0, tmo0},  32'd0);
    chk({tag, ".fidx"},  {30'd0, fidx0}, 32'd0);
    chk({tag, ".match"}, {28'd0, m0},    32'd0);
    chk({tag, ".cnt"},   {24'd0, cnt0},  32'd0);
  endtask

  initial begin
    reset = 1'b1; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    check_en = '0; check_addr = '0; check_val = '0;

    // 1: single channel, matching write on edge 50
    do_reset(4'b0001, {48'h0, 16'h022A}, {24'h0, 8'h55});
    chk_idle0("t1.rst");
    idle(49);
    chk("t1.pre.done", {31'd0, done0}, 32'd0);
    chk("t1.pre.cnt",  {24'd0, cnt0},  32'd49);
    step(1'b1, 16'h022A, 8'h55);
    chk("t1.pass",  {31'd0, pass0}, 32'd1);
    chk("t1.done",  {31'd0, done0}, 32'd1);
    chk("t1.tmo",   {31'd0, tmo0},  32'd0);
    chk("t1.fail",  {31'd0, fail0}, 32'd0);
    chk("t1.cnt",   {24'd0, cnt0},  32'd50);
    chk("t1.match", {28'd0, m0},    32'h1);
    step(1'b1, 16'h022A, 8'h12);
    idle(3);
    chk("t1.hold.cnt",   {24'd0, cnt0},  32'd50);
    chk("t1.hold.match", {28'd0, m0},    32'h1);
    chk("t1.hold.pass",  {31'd0, pass0}, 32'd1);

    // 2: no writes, timeout after edge 175
    do_reset(4'b0001, {48'h0, 16'h022A}, {24'h0, 8'h55});
    chk_idle0("t2.rst");
    idle(174);
    chk("t2.pre.done", {31'd0, done0}, 32'd0);
    chk("t2.pre.cnt",  {24'd0, cnt0},  32'd174);
    idle(1);
    chk("t2.done", {31'd0, done0}, 32'd1);
    chk("t2.fail", {31'd0, fail0}, 32'd1);
    chk("t2.tmo",  {31'd0, tmo0},  32'd1);
    chk("t2.pass", {31'd0, pass0}, 32'd0);
    chk("t2.cnt",  {24'd0, cnt0},  32'd175);
    idle(2);
    chk("t2.hold.cnt", {24'd0, cnt0}, 32'd175);

    // 3: shared address, strict fail picks lowest mismatching channel
    do_reset(4'b1101, {16'h0200, 16'h0200, 16'h0000, 16'h0200},
             {8'hCC, 8'hBB, 8'h00, 8'hAA});
    step(1'b1, 16'h0200, 8'hAA);
    chk("t3.s.fail",  {31'd0, fail1}, 32'd1);
    chk("t3.s.done",  {31'd0, done1}, 32'd1);
    chk("t3.s.tmo",   {31'd0, tmo1},  32'd0);
    chk("t3.s.fidx",  {30'd0, fidx1}, 32'd2);
    chk("t3.s.match", {28'd0, m1},    32'h1);
    chk("t3.s.cnt",   {24'd0, cnt1},  32'd1);
    chk("t3.l.match", {28'd0, m0},    32'h1);
    chk("t3.l.done",  {31'd0, done0}, 32'd0);

    // 4: lenient toggling; disabled ch2 shares ch0's address
    do_reset(4'b0011, {16'h0000, 16'h0100, 16'h0104, 16'h0100},
             {8'h00, 8'h11, 8'h22, 8'h11});
    check_val = 32'hFFFF_FFFF;
    step(1'b1, 16'h0104, 8'h99);
    chk("t4.m0", {28'd0, m0}, 32'h0);
    step(1'b1, 16'h0104, 8'h22);
    chk("t4.m1", {28'd0, m0}, 32'h2);
    step(1'b1, 16'h0104, 8'h23);
    chk("t4.m2", {28'd0, m0}, 32'h0);
    step(1'b1, 16'h0104, 8'h22);
    chk("t4.m3", {28'd0, m0}, 32'h2);
    chk("t4.pre.done", {31'd0, done0}, 32'd0);
    step(1'b1, 16'h0100, 8'h11);
    chk("t4.m4",   {28'd0, m0},    32'h3);
    chk("t4.pass", {31'd0, pass0}, 32'd1);
    chk("t4.cnt",  {24'd0, cnt0},  32'd5);

    // 5: completing write lands on the timeout edge
    do_reset(4'b0001, {48'h0, 16'h022A}, {24'h0, 8'h55});
    idle(174);
    step(1'b1, 16'h022A, 8'h55);
    chk("t5.pass", {31'd0, pass0}, 32'd1);
    chk("t5.tmo",  {31'd0, tmo0},  32'd0);
    chk("t5.fail", {31'd0, fail0}, 32'd0);
    chk("t5.cnt",  {24'd0, cnt0},  32'd175);

    // 6: reset out of PASS with new config; later config changes ignored
    do_reset(4'b0010, {16'h0, 16'h0, 16'h0300, 16'h0}, {8'h0, 8'h0, 8'h77, 8'h0});
    chk_idle0("t6.rst");
    check_en = 4'b1111; check_addr = '0; check_val = '0;
    step(1'b1, 16'h022A, 8'h55);
    chk("t6.old.match", {28'd0, m0},    32'h0);
    chk("t6.old.done",  {31'd0, done0}, 32'd0);
    step(1'b1, 16'h0300, 8'h77);
    chk("t6.match", {28'd0, m0},    32'h2);
    chk("t6.pass",  {31'd0, pass0}, 32'd1);
    chk("t6.cnt",   {24'd0, cnt0},  32'd2);

    // 7: nothing enabled -> cannot pass, ends in timeout
    do_reset(4'b0000, {48'h0, 16'h022A}, {24'h0, 8'h55});
    step(1'b1, 16'h022A, 8'h55);
    chk("t7.match", {28'd0, m0},    32'h0);
    chk("t7.done",  {31'd0, done0}, 32'd0);
    idle(173);
    chk("t7.pre.done", {31'd0, done0}, 32'd0);
    idle(1);
    chk("t7.tmo",  {31'd0, tmo0},  32'd1);
    chk("t7.pass", {31'd0, pass0}, 32'd0);
    chk("t7.cnt",  {24'd0, cnt0},  32'd175);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
